// File: rtl/capture_seg.sv
// Segmented capture controller: splits the sample RAM into NUM_SEG ring segments and
// captures one trigger window (pre/post) per segment, reporting each segment's end address.
module capture_seg #(
   parameter int ENTRIES   = 384,
   parameter int LOG2      = 9,
   parameter int NUM_SEG   = 4,
   parameter int SEG_LOG2  = 2,
   parameter int SEG_DEPTH = ENTRIES / NUM_SEG
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wrt_smpl,
   input  logic                run,
   input  logic                capture_done,
   input  logic                triggered,
   input  logic [LOG2-1:0]     trig_pos,
   input  logic [SEG_LOG2-1:0] seg_last,
   output logic                we,
   output logic [LOG2-1:0]     waddr,
   output logic                armed,
   output logic                set_capture_done,
   output logic                trig_rearm,
   output logic                seg_wr,
   output logic [SEG_LOG2-1:0] seg_idx,
   output logic [LOG2-1:0]     seg_end_addr
);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_REARM, S_WAIT_RD} state_t;

   state_t              state_q, state_d;
   logic [LOG2-1:0]     offset_q, offset_d;
   logic [LOG2-1:0]     fill_q, fill_d;
   logic [LOG2-1:0]     post_cnt_q, post_cnt_d;
   logic [SEG_LOG2-1:0] seg_idx_q, seg_idx_d;
   logic [LOG2-1:0]     seg_end_q, seg_end_d;
   logic                armed_q, armed_d;

   logic [LOG2-1:0]     tp_s, thr_s, fill_inc_s, off_inc_s, seg_base_s, waddr_s;
   logic [SEG_LOG2-1:0] last_s;
   logic                we_s, counted_s, complete_s, is_last_s;

   // Clamped window settings, write strobe and completion detection
   always_comb begin
      tp_s       = (trig_pos > LOG2'(SEG_DEPTH - 1)) ? LOG2'(SEG_DEPTH - 1) : trig_pos;
      last_s     = (int'(seg_last) > NUM_SEG - 1) ? SEG_LOG2'(NUM_SEG - 1) : seg_last;
      thr_s      = LOG2'(SEG_DEPTH - 1) - tp_s;
      fill_inc_s = (fill_q == LOG2'(SEG_DEPTH)) ? fill_q : fill_q + LOG2'(1);
      off_inc_s  = (offset_q == LOG2'(SEG_DEPTH - 1)) ? LOG2'(0) : offset_q + LOG2'(1);
      seg_base_s = LOG2'(seg_idx_q) * LOG2'(SEG_DEPTH);
      waddr_s    = seg_base_s + offset_q;
      we_s       = wrt_smpl & run & ~capture_done & (state_q == S_CAPTURE);
      // A trigger seen before the pre-trigger window is full is deliberately ignored
      counted_s  = we_s & triggered & armed_q;
      complete_s = counted_s & (post_cnt_q == tp_s);
      is_last_s  = (seg_idx_q == last_s);
   end

   // Next-state logic for the capture sequencer and its counters
   always_comb begin
      state_d    = state_q;
      offset_d   = offset_q;
      fill_d     = fill_q;
      post_cnt_d = post_cnt_q;
      seg_idx_d  = seg_idx_q;
      seg_end_d  = seg_end_q;
      armed_d    = armed_q;
      case (state_q)
         S_IDLE: begin
            armed_d = 1'b0;
            if (run) begin
               offset_d   = LOG2'(0);
               fill_d     = LOG2'(0);
               post_cnt_d = LOG2'(0);
               seg_idx_d  = SEG_LOG2'(0);
               state_d    = S_CAPTURE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CAPTURE: begin
            if (!run) begin
               armed_d = 1'b0;
               state_d = S_IDLE;
            end else if (complete_s) begin
               seg_end_d = waddr_s;
               armed_d   = 1'b0;
               if (is_last_s) begin
                  offset_d = off_inc_s;
                  fill_d   = fill_inc_s;
                  state_d  = S_WAIT_RD;
               end else begin
                  seg_idx_d  = seg_idx_q + SEG_LOG2'(1);
                  offset_d   = LOG2'(0);
                  fill_d     = LOG2'(0);
                  post_cnt_d = LOG2'(0);
                  state_d    = S_REARM;
               end
            end else if (we_s) begin
               offset_d = off_inc_s;
               fill_d   = fill_inc_s;
               if (counted_s) begin
                  post_cnt_d = post_cnt_q + LOG2'(1);
               end else begin
                  post_cnt_d = post_cnt_q;
               end
               if (fill_inc_s >= thr_s) begin
                  armed_d = 1'b1;
               end else begin
                  armed_d = armed_q;
               end
            end else begin
               state_d = S_CAPTURE;
            end
         end
         S_REARM: begin
            if (!run) begin
               armed_d = 1'b0;
               state_d = S_IDLE;
            end else if (!triggered) begin
               state_d = S_CAPTURE;
            end else begin
               state_d = S_REARM;
            end
         end
         S_WAIT_RD: begin
            if (!capture_done) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT_RD;
            end
         end
         default: begin
            armed_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         offset_q   <= LOG2'(0);
         fill_q     <= LOG2'(0);
         post_cnt_q <= LOG2'(0);
         seg_idx_q  <= SEG_LOG2'(0);
         seg_end_q  <= LOG2'(0);
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         offset_q   <= offset_d;
         fill_q     <= fill_d;
         post_cnt_q <= post_cnt_d;
         seg_idx_q  <= seg_idx_d;
         seg_end_q  <= seg_end_d;
         armed_q    <= armed_d;
      end
   end

   assign we               = we_s;
   assign waddr            = waddr_s;
   assign armed            = armed_q;
   assign seg_wr           = complete_s;
   assign set_capture_done = complete_s & is_last_s;
   assign trig_rearm       = complete_s & ~is_last_s;
   assign seg_idx          = seg_idx_q;
   assign seg_end_addr     = seg_end_q;

endmodule
